// File: rtl/ccff_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ccff_loader_pkg
//  Description : Shared types and CRC-8 helper for the configuration
//                flip-flop chain loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package ccff_loader_pkg;

    // Loader sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // One serial step of CRC-8 (MSB-first, no reflection, no final XOR)
    function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage : ccff_loader_pkg
`default_nettype wire

// File: rtl/ccff_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : ccff_word_serializer
//  Description : One-word buffer behind a valid/ready handshake that hands
//                its bits out MSB-first through a bit_valid/bit_take port.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccff_word_serializer #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_fetch_en,
    input  logic              i_word_valid,
    input  logic [WORD_W-1:0] i_word_data,
    output logic              o_word_ready,
    input  logic              i_bit_take,
    output logic              o_bit_valid,
    output logic              o_bit_data
);

    localparam int              SC_W   = $clog2(WORD_W + 1);
    localparam logic [SC_W-1:0] C_FULL = SC_W'(WORD_W);
    localparam logic [SC_W-1:0] C_ONE  = SC_W'(1);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [SC_W-1:0]   cnt_q, cnt_d;
    logic              w_empty_next;
    logic              w_accept;

    // The buffer counts as empty when it already is, or when its last bit
    // leaves this cycle; that lets a new word land without a bubble.
    assign w_empty_next = (cnt_q == '0) || ((cnt_q == C_ONE) && i_bit_take);
    assign o_word_ready = i_fetch_en && w_empty_next;
    assign w_accept     = o_word_ready && i_word_valid;
    assign o_bit_valid  = (cnt_q != '0);
    assign o_bit_data   = shreg_q[WORD_W-1];

    // Next buffer contents: flush, shift out one bit, and/or load a new word
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (i_flush) begin
            cnt_d = '0;
        end else begin
            if (i_bit_take) begin
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q - C_ONE;
            end
            if (w_accept) begin
                shreg_d = i_word_data;
                cnt_d   = C_FULL;
            end
        end
    end

    // Buffer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : ccff_word_serializer
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ccff_chain_loader
//  Description : Loads a tile's configuration flip-flop chain from a word
//                stream, gating prog_clk for exactly CHAIN_LEN shifts, then
//                optionally recirculates the chain once to CRC-check it.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8,
    parameter int VERIFY_EN = 1,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [CNT_W-1:0] C_LEN    = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] C_LEN_M1 = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
    localparam logic [CNT_W:0]   C_LEN_X  = (CNT_W + 1)'(CHAIN_LEN);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       crc_load_q, crc_load_d;
    logic [7:0]       crc_ver_q, crc_ver_d;
    logic             head_q, head_d;
    logic             shift_en_q, shift_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             w_in_load;
    logic             w_bit_valid;
    logic             w_bit_data;
    logic             w_bit_take;
    logic             w_fetch_en;
    logic             w_flush;
    logic [CNT_W:0]   w_cnt_after;

    assign w_in_load   = (state_q == ST_LOAD);
    assign w_bit_take  = w_in_load && w_bit_valid && (bit_cnt_q < C_LEN);
    // Only fetch another word if, after this cycle's shift, the chain still
    // needs bits; otherwise the stream's surplus is never touched.
    assign w_cnt_after = {1'b0, bit_cnt_q} + {{CNT_W{1'b0}}, w_bit_take};
    assign w_fetch_en  = w_in_load && (w_cnt_after < C_LEN_X);

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .clk          (prog_clk),
        .rst          (pReset),
        .i_flush      (w_flush),
        .i_fetch_en   (w_fetch_en),
        .i_word_valid (word_valid),
        .i_word_data  (word_data),
        .o_word_ready (word_ready),
        .i_bit_take   (w_bit_take),
        .o_bit_valid  (w_bit_valid),
        .o_bit_data   (w_bit_data)
    );

    // During the verify pass the chain is closed into a ring through the head
    assign ccff_head = (state_q == ST_VERIFY) ? ccff_tail : head_q;
    assign shift_en  = shift_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

    // Next-state and registered-output logic for the load/verify sequencer
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        crc_load_d = crc_load_q;
        crc_ver_d  = crc_ver_q;
        head_d     = head_q;
        shift_en_d = shift_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        w_flush    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                shift_en_d = 1'b0;
                if (start && !abort) begin
                    state_d    = ST_LOAD;
                    bit_cnt_d  = '0;
                    crc_load_d = CRC8_INIT;
                    crc_ver_d  = CRC8_INIT;
                    error_d    = 1'b0;
                    busy_d     = 1'b1;
                    w_flush    = 1'b1;
                end
            end

            ST_LOAD: begin
                if (bit_cnt_q == C_LEN) begin
                    // The final bit is on the head this cycle; drop any
                    // leftover bits of the last word.
                    w_flush = 1'b1;
                    if (VERIFY_EN != 0) begin
                        state_d    = ST_VERIFY;
                        bit_cnt_d  = '0;
                        shift_en_d = 1'b1;
                    end else begin
                        state_d    = ST_DONE;
                        shift_en_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end
                end else if (w_bit_take) begin
                    head_d     = w_bit_data;
                    shift_en_d = 1'b1;
                    bit_cnt_d  = bit_cnt_q + C_ONE;
                    crc_load_d = crc8_bit(crc_load_q, w_bit_data);
                end else begin
                    shift_en_d = 1'b0;
                end
            end

            ST_VERIFY: begin
                // shift_en is high for every cycle spent here
                crc_ver_d = crc8_bit(crc_ver_q, ccff_tail);
                bit_cnt_d = bit_cnt_q + C_ONE;
                if (bit_cnt_q == C_LEN_M1) begin
                    state_d    = ST_DONE;
                    shift_en_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    if (crc_ver_d != crc_load_q) begin
                        error_d = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d    = ST_IDLE;
                shift_en_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase

        // abort outranks every other transition once a load is underway
        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            shift_en_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            error_d    = 1'b1;
            head_d     = 1'b0;
            w_flush    = 1'b1;
        end
    end

    // Sequencer state and output registers
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            crc_load_q <= CRC8_INIT;
            crc_ver_q  <= CRC8_INIT;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            crc_load_q <= crc_load_d;
            crc_ver_q  <= crc_ver_d;
            head_q     <= head_d;
            shift_en_q <= shift_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

endmodule : ccff_chain_loader
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ccff_chain_loader
//  Description : Self-checking bench for ccff_chain_loader; a 16-bit and a
//                12-bit chain, each modelled as a plain shift register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] start_v = '0;
    logic [1:0] abort_v = '0;
    logic [1:0] vv_v    = '0;
    logic [1:0] fault_v = '0;
    logic [7:0] wd0 = '0;
    logic [7:0] wd1 = '0;
    wire  [1:0] wr_v, head_v, se_v, busy_v, done_v, err_v, tail_v;

    logic [15:0] chain0 = '0;
    logic [11:0] chain1 = '0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8), .VERIFY_EN(1)) dut16 (
        .prog_clk (clk),       .pReset (rst),
        .start    (start_v[0]), .abort (abort_v[0]),
        .word_valid (vv_v[0]), .word_data (wd0), .word_ready (wr_v[0]),
        .ccff_head (head_v[0]), .ccff_tail (tail_v[0]),
        .shift_en (se_v[0]), .busy (busy_v[0]), .done (done_v[0]), .error (err_v[0])
    );

    ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8), .VERIFY_EN(1)) dut12 (
        .prog_clk (clk),       .pReset (rst),
        .start    (start_v[1]), .abort (abort_v[1]),
        .word_valid (vv_v[1]), .word_data (wd1), .word_ready (wr_v[1]),
        .ccff_head (head_v[1]), .ccff_tail (tail_v[1]),
        .shift_en (se_v[1]), .busy (busy_v[1]), .done (done_v[1]), .error (err_v[1])
    );

    // Chain models: capture head on every gated clock edge; optional stuck-at-0 tail
    assign tail_v = {fault_v[1] ? 1'b0 : chain1[11], fault_v[0] ? 1'b0 : chain0[15]};

    always @(posedge clk) begin
        if (se_v[0]) chain0 <= {chain0[14:0], head_v[0]};
        if (se_v[1]) chain1 <= {chain1[10:0], head_v[1]};
    end

    // Reference CRC-8 (poly 0x07, init 0) over the n low bits of v, MSB first
    function automatic logic [7:0] ref_crc(input logic [15:0] v, input int n);
        logic [7:0] c;
        logic       b;
        c = 8'h00;
        for (int j = 0; j < n; j++) begin
            b = v[n-1-j];
            if (c[7] ^ b) c = {c[6:0], 1'b0} ^ 8'h07;
            else          c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // Full load (+ verify) on one DUT, with optional bubbles before words 1/2
    task automatic run_load(input int sel, input int nw,
                            input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input int b1, input int b2, input bit fault);
        logic [7:0]  w [3];
        int          bub [3];
        int          n, wi, bub_left, first_k, highs, gaps, pend, done_cnt, extra_ready, post;
        int          exp_gaps;
        bit          fin;
        logic        err_at_done;
        logic [15:0] expv, exp_chain, chain_now;
        logic        exp_err;

        w[0] = w0; w[1] = w1; w[2] = w2;
        bub[0] = 0; bub[1] = b1; bub[2] = b2;
        n = (sel == 1) ? 12 : 16;
        wi = 0; bub_left = 0; first_k = -1; highs = 0; gaps = 0; pend = 0;
        done_cnt = 0; extra_ready = 0; post = 0; fin = 1'b0; err_at_done = 1'bx;

        // Expected chain: first n bits of the word stream, MSB first
        expv = '0;
        for (int i = 0; i < n; i++) expv = {expv[14:0], w[i/8][7-(i%8)]};
        exp_err   = fault && (ref_crc(expv, n) != ref_crc(16'h0000, n));
        exp_chain = fault ? 16'h0000 : expv;
        exp_gaps  = (nw > 1 ? b1 : 0) + (nw > 2 ? b2 : 0);

        fault_v[sel] = fault;
        @(negedge clk);
        start_v[sel] = 1'b1;
        for (int k = 0; k < 400 && post < 3; k++) begin
            @(negedge clk);
            start_v[sel] = 1'b0;
            if (k == 0) begin
                vectors++;
                if (busy_v[sel] !== 1'b1 || err_v[sel] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL start_accept: busy=%b error=%b want busy=1 error=0", busy_v[sel], err_v[sel]);
                end
            end
            if (se_v[sel]) begin
                if (first_k < 0) first_k = k;
                highs++;
                gaps += pend;
                pend = 0;
            end else if (first_k >= 0 && !fin) begin
                pend++;
            end
            if (done_v[sel]) begin
                done_cnt++;
                err_at_done = err_v[sel];
                fin = 1'b1;
            end
            if (fin) post++;
            if (wi < nw) begin
                if (bub_left > 0) begin
                    vv_v[sel] = 1'b0;
                    if (wr_v[sel]) bub_left--;
                end else begin
                    vv_v[sel] = 1'b1;
                    if (sel == 1) wd1 = w[wi]; else wd0 = w[wi];
                    if (wr_v[sel]) begin
                        wi++;
                        if (wi < nw) bub_left = bub[wi];
                    end
                end
            end else begin
                vv_v[sel] = 1'b0;
                if (wr_v[sel]) extra_ready++;
            end
        end
        vv_v[sel] = 1'b0;
        chain_now = (sel == 1) ? {4'h0, chain1} : chain0;

        vectors++;
        if (fin !== 1'b1) begin miscompares++; $display("FAIL done_seen: got %0d want 1", fin); end
        vectors++;
        if (first_k != 2) begin miscompares++; $display("FAIL first_shift_latency: got %0d want 2", first_k); end
        vectors++;
        if (highs != 2 * n) begin miscompares++; $display("FAIL shift_count: got %0d want %0d", highs, 2 * n); end
        vectors++;
        if (gaps != exp_gaps) begin miscompares++; $display("FAIL shift_gaps: got %0d want %0d", gaps, exp_gaps); end
        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL done_pulses: got %0d want 1", done_cnt); end
        vectors++;
        if (err_at_done !== exp_err) begin miscompares++; $display("FAIL error_at_done: got %b want %b", err_at_done, exp_err); end
        vectors++;
        if (chain_now !== exp_chain) begin miscompares++; $display("FAIL chain_contents: got %h want %h", chain_now, exp_chain); end
        vectors++;
        if (wi != nw || extra_ready != 0) begin
            miscompares++;
            $display("FAIL words_consumed: got %0d words, %0d extra ready cycles; want %0d, 0", wi, extra_ready, nw);
        end
        vectors++;
        if (busy_v[sel] !== 1'b0) begin miscompares++; $display("FAIL busy_after_done: got %b want 0", busy_v[sel]); end
        fault_v[sel] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({wr_v, head_v, se_v, busy_v, done_v, err_v} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 000", {wr_v, head_v, se_v, busy_v, done_v, err_v});
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy_v, se_v, wr_v} !== 6'h00) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %h want 00", {busy_v, se_v, wr_v});
        end
    endtask

    task automatic test_basic_load();
        run_load(0, 2, 8'hA5, 8'h3C, 8'h00, 0, 0, 1'b0);
    endtask

    task automatic test_bubble();
        run_load(0, 2, 8'hA5, 8'h3C, 8'h00, 3, 0, 1'b0);
    endtask

    task automatic test_leftover();
        run_load(1, 2, 8'hFF, 8'h0F, 8'h00, 0, 0, 1'b0);
    endtask

    task automatic test_stuck_fault();
        run_load(0, 2, 8'hA5, 8'h3C, 8'h00, 0, 0, 1'b1);
        repeat (2) @(negedge clk);
        vectors++;
        if (err_v[0] !== 1'b1) begin miscompares++; $display("FAIL error_sticky: got %b want 1", err_v[0]); end
        run_load(0, 2, 8'hA5, 8'h3C, 8'h00, 0, 0, 1'b0);
    endtask

    task automatic test_abort();
        int highs = 0;
        int rdy = 0;
        int dn = 0;
        bit hit = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b1;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            vv_v[0] = 1'b1;
            wd0 = 8'($urandom);
            if (se_v[0]) highs++;
            if (highs == 5) begin
                abort_v[0] = 1'b1;
                hit = 1'b1;
            end
        end
        vectors++;
        if (hit !== 1'b1) begin miscompares++; $display("FAIL abort_reached: got %0d shifts want 5", highs); end
        @(negedge clk);
        abort_v[0] = 1'b0;
        vectors++;
        if ({busy_v[0], se_v[0], err_v[0], done_v[0]} !== 4'b0010) begin
            miscompares++;
            $display("FAIL abort_response: busy,shift_en,error,done got %b want 0010",
                     {busy_v[0], se_v[0], err_v[0], done_v[0]});
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (wr_v[0]) rdy++;
            if (done_v[0]) dn++;
        end
        vv_v[0] = 1'b0;
        vectors++;
        if (rdy != 0 || dn != 0) begin
            miscompares++;
            $display("FAIL after_abort_quiet: ready cycles %0d done cycles %0d want 0 0", rdy, dn);
        end
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk);
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        vectors++;
        if ({busy_v[0], wr_v[0], err_v[0]} !== 3'b001) begin
            miscompares++;
            $display("FAIL start_abort_idle: busy,ready,error got %b want 001", {busy_v[0], wr_v[0], err_v[0]});
        end
    endtask

    task automatic test_preset_mid_verify();
        int highs = 0;
        int wi = 0;
        bit hit = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b1;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            vv_v[0] = (wi < 2);
            wd0 = (wi == 0) ? 8'hA5 : 8'h3C;
            if (wr_v[0] && vv_v[0]) wi++;
            if (se_v[0]) highs++;
            if (highs == 20) begin
                vv_v[0] = 1'b0;
                rst = 1'b1;
                hit = 1'b1;
            end
        end
        #1;
        vectors++;
        if (hit !== 1'b1) begin miscompares++; $display("FAIL verify_reached: got %0d shifts want 20", highs); end
        vectors++;
        if ({wr_v[0], head_v[0], se_v[0], busy_v[0], done_v[0], err_v[0]} !== 6'b000000) begin
            miscompares++;
            $display("FAIL async_reset_outputs: got %b want 000000",
                     {wr_v[0], head_v[0], se_v[0], busy_v[0], done_v[0], err_v[0]});
        end
        @(negedge clk);
        rst = 1'b0;
        run_load(0, 2, 8'hA5, 8'h3C, 8'h00, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            run_load(it % 2, 2, 8'($urandom), 8'($urandom), 8'h00,
                     int'($urandom_range(0, 3)), 0, ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_bubble();
        test_leftover();
        test_stuck_fault();
        test_abort();
        test_start_abort_idle();
        test_preset_mid_verify();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ccff_chain_loader
`default_nettype wire

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Sequences the configuration flip-flop chain of a connection/switch block tile.
- Accepts bitstream words over a valid/ready interface and serialises them MSB-first onto ccff_head.
- Produces the shift enable that gates the chain's prog_clk for exactly CHAIN_LEN bits.
- Optionally recirculates the chain (ccff_tail back to ccff_head) for CHAIN_LEN more shifts to CRC-check the loaded contents without disturbing them.

Parameters:
- CHAIN_LEN, 16: number of configuration bits in the chain (4 muxes x 4 SRAM bits); minimum 1.
- WORD_W, 8: bitstream word width; minimum 1.
- VERIFY_EN, 1: 1 enables the recirculate/CRC pass; 0 skips it.
- CNT_W, $clog2(CHAIN_LEN+1): bit counter width (derived; do not override).

Ports:
- prog_clk  in  1  programming clock; all state on the rising edge.
- pReset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
- abort  in  1  cancels a load or verify in progress.
- word_valid  in  1  bitstream word available.
- word_data  in  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- word_ready  out  1  word accepted when word_valid && word_ready.
- ccff_head  out  1  serial data into the chain.
- ccff_tail  in  1  serial data out of the chain.
- shift_en  out  1  chain clock-gate enable; the chain captures ccff_head on a prog_clk edge where shift_en=1.
- busy  out  1  high in LOAD and VERIFY.
- done  out  1  one-cycle pulse on completion.
- error  out  1  sticky; set on CRC mismatch or abort, cleared by the next accepted start.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0; CRC registers 0x00.
- FSM states: IDLE, LOAD, VERIFY, DONE.
- IDLE -> LOAD on start. Clear bit_cnt, crc_load, crc_ver and error.
- LOAD, word fetch:
  - word_ready=1 only when the shift buffer is empty and bit_cnt < CHAIN_LEN.
  - An accepted word loads the buffer; its first bit drives head_q on the next cycle.
- LOAD, shift: each cycle the buffer holds a bit:
  - head_q <= buffer MSB; shift_en <= 1; bit_cnt++; crc_load updates with that bit.
- LOAD, stall: buffer empty and no word available -> shift_en <= 0. Stalls are allowed anywhere and the chain holds its contents.
- LOAD, back-to-back: a new word may be accepted in the same cycle the last buffered bit shifts, so there are no bubbles when word_valid stays high.
- LOAD exit: when bit_cnt reaches CHAIN_LEN:
  - Leftover bits of the final word are discarded; that word counts as consumed.
  - Go to VERIFY if VERIFY_EN=1, else DONE.
- VERIFY:
  - ccff_head = ccff_tail (combinational mux; head_q everywhere else).
  - shift_en=1 for exactly CHAIN_LEN consecutive cycles; crc_ver updates with ccff_tail on each of those cycles.
  - Chain contents are unchanged after the pass.
  - Then go to DONE.
- DONE: done=1 for one cycle; error |= (VERIFY_EN && crc_ver != crc_load); go to IDLE.
- CRC: CRC-8, polynomial 0x07, init 0x00, one bit per update, no reflection, no final XOR.
- shift_en is registered and aligned with head_q. In VERIFY it is also registered, with the mux selecting the live ccff_tail.
- Latency: with word_valid held high, start -> first shift_en = 2 cycles. Total LOAD shift cycles = CHAIN_LEN.
- abort (any state except IDLE):
  - Next cycle: IDLE, shift_en=0, error=1, done not pulsed.
  - Chain contents are undefined.
  - abort has priority over every other transition in the same cycle.
- start while busy is ignored. start and abort together in IDLE -> stay in IDLE.
- pReset mid-operation: immediate return to reset values; shift_en drops asynchronously.

Decomposition:
- Shared package ccff_loader_pkg holds:
  - FSM state enum;
  - CRC8_POLY = 8'h07 and CRC8_INIT = 8'h00;
  - function crc8_bit(crc, bit).
- One sub-module, ccff_word_serializer: word buffer, valid/ready handshake and MSB-first shift, with a bit_valid/bit_take interface to the FSM.
- CRC is the package function instantiated twice (crc_load, crc_ver); no separate module.

Test Plan:
- CHAIN_LEN=16, WORD_W=8, words 0xA5 then 0x3C presented continuously, chain model is a 16-bit shift register -> 16 consecutive shift_en cycles, chain = 0xA53C, then 16 VERIFY cycles; done pulses, error=0.
- Same load with word_valid low for 3 cycles between the two words -> shift_en low for exactly those bubble cycles, final chain = 0xA53C, error=0.
- CHAIN_LEN=12, words 0xFF, 0x0F -> only the upper 4 bits of the second word shift; 12 shift_en cycles; both words consumed; chain = 0xFF0.
- Chain model with a stuck-at-0 fault on tail during VERIFY, load 0xA53C -> crc_ver != crc_load, done pulses, error=1; next start clears error.
- abort asserted on the 5th LOAD shift -> next cycle busy=0, shift_en=0, error=1, no done pulse; word_ready stays 0 until a new start.
- pReset asserted mid-VERIFY -> all outputs 0 asynchronously; after release a full 0xA53C load completes with error=0.
